// File: rtl/data_mem_arbiter.sv
// Two-requester round-robin sequencer for the 32x8 data memory.
// Each granted transaction drives the memory port for one cycle, then returns a one-cycle ack.
module data_mem_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              req0_i,
    input  logic              req1_i,
    input  logic              we0_i,
    input  logic              we1_i,
    input  logic [ADDR_W-1:0] addr0_i,
    input  logic [ADDR_W-1:0] addr1_i,
    input  logic [DATA_W-1:0] wdata0_i,
    input  logic [DATA_W-1:0] wdata1_i,
    output logic              ack0_o,
    output logic              ack1_o,
    output logic [DATA_W-1:0] rdata0_o,
    output logic [DATA_W-1:0] rdata1_o,
    output logic [ADDR_W-1:0] mem_address_o,
    output logic [DATA_W-1:0] mem_write_data_o,
    output logic              mem_write_o,
    output logic              mem_read_o,
    input  logic [DATA_W-1:0] mem_read_data_i,
    output logic              busy_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              last_gnt_q, last_gnt_d;
    logic              gnt_q, gnt_d;
    logic              win_s;
    logic              ack0_q, ack0_d, ack1_q, ack1_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_write_q, mem_write_d;
    logic              mem_read_q, mem_read_d;
    logic              busy_q, busy_d;

    // Next-state and next-output logic; memory-port outputs default to zero outside ACCESS.
    always_comb begin
        state_d     = state_q;
        last_gnt_d  = last_gnt_q;
        gnt_d       = gnt_q;
        win_s       = 1'b0;
        ack0_d      = 1'b0;
        ack1_d      = 1'b0;
        rdata0_d    = rdata0_q;
        rdata1_d    = rdata1_q;
        mem_addr_d  = {ADDR_W{1'b0}};
        mem_wdata_d = {DATA_W{1'b0}};
        mem_write_d = 1'b0;
        mem_read_d  = 1'b0;
        busy_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req0_i || req1_i) begin
                    // A lone request wins outright; a tie goes to the port not granted last.
                    if (req0_i && req1_i) begin
                        win_s = ~last_gnt_q;
                    end else begin
                        win_s = req1_i;
                    end
                    gnt_d      = win_s;
                    last_gnt_d = win_s;
                    state_d    = ST_ACCESS;
                    busy_d     = 1'b1;
                    if (win_s) begin
                        mem_write_d = we1_i;
                        mem_read_d  = ~we1_i;
                        mem_addr_d  = addr1_i;
                        mem_wdata_d = wdata1_i;
                    end else begin
                        mem_write_d = we0_i;
                        mem_read_d  = ~we0_i;
                        mem_addr_d  = addr0_i;
                        mem_wdata_d = wdata0_i;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                state_d = ST_RESP;
                busy_d  = 1'b1;
                if (gnt_q) begin
                    ack1_d = 1'b1;
                end else begin
                    ack0_d = 1'b1;
                end
                if (mem_read_q && gnt_q) begin
                    rdata1_d = mem_read_data_i;
                end else if (mem_read_q) begin
                    rdata0_d = mem_read_data_i;
                end else begin
                    rdata0_d = rdata0_q;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset clears the memory strobes immediately.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_IDLE;
            last_gnt_q  <= 1'b1;
            gnt_q       <= 1'b0;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            rdata0_q    <= {DATA_W{1'b0}};
            rdata1_q    <= {DATA_W{1'b0}};
            mem_addr_q  <= {ADDR_W{1'b0}};
            mem_wdata_q <= {DATA_W{1'b0}};
            mem_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_gnt_q  <= last_gnt_d;
            gnt_q       <= gnt_d;
            ack0_q      <= ack0_d;
            ack1_q      <= ack1_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_write_q <= mem_write_d;
            mem_read_q  <= mem_read_d;
            busy_q      <= busy_d;
        end
    end

    assign ack0_o           = ack0_q;
    assign ack1_o           = ack1_q;
    assign rdata0_o         = rdata0_q;
    assign rdata1_o         = rdata1_q;
    assign mem_address_o    = mem_addr_q;
    assign mem_write_data_o = mem_wdata_q;
    assign mem_write_o      = mem_write_q;
    assign mem_read_o       = mem_read_q;
    assign busy_o           = busy_q;

endmodule
